// File: rtl/downsample_ctrl.sv
// downsample_ctrl: keeps one sample per frame of ratio_reg valid inputs at a
// programmable phase. The kept sample is held in a one-deep registered
// valid/ready output slot. The block also keeps a sticky overrun flag and a
// count of delivered samples.
module downsample_ctrl #(
   parameter int DATA_W        = 16,
   parameter int RATIO_W       = 4,
   parameter int DEFAULT_RATIO = 6
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                enable,
   input  logic                cfg_load,
   input  logic [RATIO_W-1:0]  cfg_ratio,
   input  logic [RATIO_W-1:0]  cfg_phase,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   input  logic                out_ready,
   output logic                busy,
   output logic                overrun,
   output logic [15:0]         sample_cnt
);

   localparam logic [RATIO_W-1:0] RATIO_ONE = RATIO_W'(1);
   localparam logic [RATIO_W-1:0] DEF_RATIO = RATIO_W'(DEFAULT_RATIO);
   localparam logic [RATIO_W-1:0] DEF_PHASE = RATIO_W'(DEFAULT_RATIO - 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t              state_reg, state_next;
   logic                run;
   logic [RATIO_W-1:0]  ratio_reg, phase_reg, cnt_reg;
   logic [RATIO_W-1:0]  ratio_eff, phase_eff;
   logic                out_valid_reg, overrun_reg;
   logic [DATA_W-1:0]   out_data_reg;
   logic [15:0]         sample_cnt_reg;
   logic                keep, handshake;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic: enable alone moves between idle and running
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (enable)  state_next = ST_RUN;
         ST_RUN:  if (!enable) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      run  = (state_reg == ST_RUN);
      busy = run || out_valid_reg;
   end

   // Sanitised config: ratio 0 acts as 1, phase clamped into the frame
   always_comb begin
      ratio_eff = (cfg_ratio == '0) ? RATIO_ONE : cfg_ratio;
      phase_eff = (cfg_phase > (ratio_eff - RATIO_ONE)) ? (ratio_eff - RATIO_ONE) : cfg_phase;
   end

   // A sample arriving with cfg_load is discarded, so it can never be kept
   always_comb begin
      keep      = run && in_valid && !cfg_load && (cnt_reg == phase_reg);
      handshake = out_valid_reg && out_ready;
   end

   // Config registers and frame counter; leaving RUN restarts the frame
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         ratio_reg <= DEF_RATIO;
         phase_reg <= DEF_PHASE;
         cnt_reg   <= '0;
      end else if (cfg_load) begin
         ratio_reg <= ratio_eff;
         phase_reg <= phase_eff;
         cnt_reg   <= '0;
      end else if (run && !enable) begin
         cnt_reg   <= '0;
      end else if (run && in_valid) begin
         cnt_reg   <= (cnt_reg == (ratio_reg - RATIO_ONE)) ? '0 : (cnt_reg + RATIO_ONE);
      end
   end

   // Output slot: load on keep when free or draining this edge, else flag overrun
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         overrun_reg    <= 1'b0;
         sample_cnt_reg <= '0;
      end else begin
         if (handshake)
            sample_cnt_reg <= sample_cnt_reg + 16'd1;
         if (keep && (!out_valid_reg || out_ready)) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data;
         end else if (handshake) begin
            out_valid_reg <= 1'b0;
         end
         if (cfg_load)
            overrun_reg <= 1'b0;
         else if (keep && out_valid_reg && !out_ready)
            overrun_reg <= 1'b1;
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign overrun    = overrun_reg;
   assign sample_cnt = sample_cnt_reg;

endmodule

// File: tb/tb_downsample_ctrl.sv
// Testbench for downsample_ctrl: directed scenarios plus randomized traffic,
// all checked against a sample-index reference model.
module tb_downsample_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1, enable = 1'b0, cfg_load = 1'b0;
   logic [3:0]  cfg_ratio = '0, cfg_phase = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic        out_valid, busy, overrun;
   logic [15:0] out_data, sample_cnt;

   int errors = 0;
   int checks = 0;

   // reference model: frame position is simply (sample index mod ratio)
   bit          m_run, m_valid, m_ovr;
   int          m_idx, m_ratio, m_phase;
   logic [15:0] m_data, m_cnt;

   downsample_ctrl #(.DATA_W(16), .RATIO_W(4), .DEFAULT_RATIO(6)) dut (
      .CLOCK_50(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
      .cfg_ratio(cfg_ratio), .cfg_phase(cfg_phase), .in_valid(in_valid),
      .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .overrun(overrun), .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [34:0] obs_vec();
      return {out_valid, out_data, overrun, sample_cnt, busy};
   endfunction

   function automatic logic [34:0] exp_vec();
      return {m_valid, m_data, m_ovr, m_cnt, (m_run || m_valid)};
   endfunction

   task automatic model_update();
      bit hs, keep;
      if (reset) begin
         m_run = 0; m_valid = 0; m_ovr = 0; m_data = '0; m_cnt = '0;
         m_idx = 0; m_ratio = 6; m_phase = 5;
      end else begin
         hs   = m_valid && out_ready;
         keep = 0;
         if (cfg_load) begin
            m_ratio = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
            m_phase = (int'(cfg_phase) < m_ratio) ? int'(cfg_phase) : m_ratio - 1;
            m_idx = 0;
            m_ovr = 0;
         end else if (m_run && in_valid) begin
            keep = ((m_idx % m_ratio) == m_phase);
            m_idx++;
         end
         if (m_run && !enable) m_idx = 0;
         if (hs) m_cnt++;
         if (keep) begin
            if (!m_valid || hs) begin m_valid = 1; m_data = in_data; end
            else m_ovr = 1;
         end else if (hs) m_valid = 0;
         m_run = enable;
      end
   endtask

   // one clock: DUT and model see the same inputs, outputs sampled 1 ns later
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; in_valid = 0; cfg_load = 0;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs_vec() !== 35'd0) begin
         errors++; $display("FAIL reset_state got %h want 0", obs_vec());
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_model got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_defaults();
      do_reset();
      enable = 1; out_ready = 1; in_valid = 0;
      step();
      for (int k = 1; k <= 20; k++) begin
         in_valid = 1; in_data = 16'(100 * k);
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL defaults_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (k % 6 == 0) begin
            checks++;
            if (!(out_valid === 1'b1 && out_data === 16'(100 * k))) begin
               errors++; $display("FAIL defaults_out k=%0d got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, 100 * k);
            end
         end
      end
      in_valid = 0;
      step();
      checks++;
      if (sample_cnt !== 16'd3 || overrun !== 1'b0) begin
         errors++; $display("FAIL defaults_count got cnt=%0d ovr=%b want cnt=3 ovr=0", sample_cnt, overrun);
      end
      $display("test_defaults done: sample_cnt=%0d", sample_cnt);
   endtask

   task automatic test_ratio_gaps();
      for (int pass = 0; pass < 2; pass++) begin
         logic [15:0] got[$];
         cfg_load = 1; cfg_ratio = 4; cfg_phase = 0; in_valid = 0;
         step();
         cfg_load = 0;
         for (int k = 1; k <= 12; k++) begin
            if (pass == 1 && $urandom_range(0, 1) == 1) begin
               in_valid = 0; step();
               if (out_valid) got.push_back(out_data);
            end
            in_valid = 1; in_data = 16'(k);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++; $display("FAIL ratio4_model pass=%0d k=%0d got %h want %h", pass, k, obs_vec(), exp_vec());
            end
            if (out_valid) got.push_back(out_data);
         end
         in_valid = 0;
         step();
         checks++;
         if (got.size() != 3 || got[0] !== 16'd1 || got[1] !== 16'd5 || got[2] !== 16'd9) begin
            errors++; $display("FAIL ratio4_outputs pass=%0d got %p want 1,5,9", pass, got);
         end
         $display("test_ratio_gaps pass %0d: %0d outputs", pass, got.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      enable = 1; out_ready = 0; in_valid = 0;
      step();
      for (int k = 1; k <= 12; k++) begin
         in_valid = 1; in_data = 16'(100 * k);
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL bp_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd600 || overrun !== 1'b1) begin
         errors++; $display("FAIL bp_hold got v=%b d=%0d ovr=%b want v=1 d=600 ovr=1", out_valid, out_data, overrun);
      end
      in_valid = 0; out_ready = 1;
      step();
      checks++;
      if (sample_cnt !== 16'd1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain got cnt=%0d v=%b want cnt=1 v=0", sample_cnt, out_valid);
      end
      cfg_load = 1; cfg_ratio = 6; cfg_phase = 5;
      step();
      cfg_load = 0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++; $display("FAIL bp_cfg_clear got ovr=%b want 0", overrun);
      end
      $display("test_backpressure done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      enable = 1; out_ready = 0; in_valid = 0;
      step();
      for (int k = 1; k <= 11; k++) begin
         in_valid = 1; in_data = 16'(100 * k);
         step();
      end
      out_ready = 1; in_data = 16'd1200;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd1200 || overrun !== 1'b0 || sample_cnt !== 16'd1) begin
         errors++; $display("FAIL b2b got v=%b d=%0d ovr=%b cnt=%0d want v=1 d=1200 ovr=0 cnt=1",
                            out_valid, out_data, overrun, sample_cnt);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL b2b_model got %h want %h", obs_vec(), exp_vec());
      end
      in_valid = 0;
      step();
      $display("test_back_to_back done");
   endtask

   task automatic test_mid_reset();
      do_reset();
      enable = 1; out_ready = 0; in_valid = 0;
      step();
      for (int k = 1; k <= 9; k++) begin
         in_valid = 1; in_data = 16'(100 * k);
         step();
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL midrst_pending got v=%b want 1", out_valid);
      end
      reset = 1;
      step();
      reset = 0;
      checks++;
      if (obs_vec() !== 35'd0) begin
         errors++; $display("FAIL midrst_clear got %h want 0", obs_vec());
      end
      out_ready = 1; in_valid = 0;
      step();
      for (int k = 1; k <= 6; k++) begin
         in_valid = 1; in_data = 16'(100 * k);
         step();
         checks++;
         if (out_valid !== (k == 6) || (k == 6 && out_data !== 16'd600)) begin
            errors++; $display("FAIL midrst_rerun k=%0d got v=%b d=%0d want v=%0d d=600", k, out_valid, out_data, k == 6);
         end
      end
      $display("test_mid_reset done");
   endtask

   task automatic test_passthrough_clamp();
      logic [15:0] got[$];
      out_ready = 1; enable = 1;
      cfg_load = 1; cfg_ratio = 0; cfg_phase = 7; in_valid = 0;
      step();
      cfg_load = 0;
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1; in_data = 16'(k);
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
            errors++; $display("FAIL pass_thru k=%0d got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, k);
         end
      end
      cfg_load = 1; cfg_ratio = 4; cfg_phase = 9; in_valid = 0;
      step();
      cfg_load = 0;
      for (int k = 1; k <= 12; k++) begin
         in_valid = 1; in_data = 16'(k);
         step();
         if (out_valid) got.push_back(out_data);
      end
      in_valid = 0;
      step();
      checks++;
      if (got.size() != 3 || got[0] !== 16'd4 || got[1] !== 16'd8 || got[2] !== 16'd12) begin
         errors++; $display("FAIL clamp_outputs got %p want 4,8,12", got);
      end
      $display("test_passthrough_clamp done");
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 600; c++) begin
         reset     = ($urandom_range(0, 99) == 0);
         cfg_load  = ($urandom_range(0, 29) == 0);
         cfg_ratio = 4'($urandom_range(0, 15));
         cfg_phase = 4'($urandom_range(0, 15));
         enable    = ($urandom_range(0, 7) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = 16'($urandom);
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; bad++;
            $display("FAIL random c=%0d got %h want %h", c, obs_vec(), exp_vec());
         end
      end
      reset = 0; cfg_load = 0;
      $display("test_random done: %0d bad cycles", bad);
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_ratio_gaps();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_passthrough_clamp();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
